// File: rtl/median_pkg.sv
// Shared definitions for the quickselect median partition stage.
package median_pkg;

    localparam int unsigned DEF_PX_W       = 8;
    localparam int unsigned DEF_CNT_W      = 16;
    localparam int unsigned DEF_BUFF_DEPTH = 1024;

    typedef enum logic [2:0] {
        ST_HDR,
        ST_FILL,
        ST_DECIDE,
        ST_EMIT_HDR,
        ST_EMIT_PX,
        ST_FOUND
    } state_t;

endpackage

// File: rtl/median_buffer_ram.sv
// Simple dual-port pixel buffer: synchronous write, registered 1-cycle read that holds when idle.
module median_buffer_ram
    import median_pkg::*;
#(
    parameter int unsigned PX_W  = DEF_PX_W,
    parameter int unsigned DEPTH = DEF_BUFF_DEPTH,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [PX_W-1:0] wr_data,
    input  logic            rd_en,
    input  logic [AW-1:0]   rd_addr,
    output logic [PX_W-1:0] rd_data
);

    logic [PX_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Read register doubles as the stage's out_px data register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)     rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/median_partition_stage.sv
// One quickselect stage: partition a packet around the pivot, then emit the median or forward one partition.
module median_partition_stage
    import median_pkg::*;
#(
    parameter int unsigned PX_W        = DEF_PX_W,
    parameter int unsigned BUFF_DEPTH  = DEF_BUFF_DEPTH,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned MEDIAN_POS  = 512,
    parameter int unsigned DEF_PIVOT   = 127,
    parameter int unsigned FIRST_STAGE = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [PX_W-1:0]  in_px,
    output logic             in_px_rd,
    input  logic             in_px_empty,
    input  logic [PX_W-1:0]  in_pivot,
    output logic             in_pivot_rd,
    input  logic             in_pivot_empty,
    input  logic [CNT_W-1:0] in_buff_size,
    output logic             in_buff_size_rd,
    input  logic             in_buff_size_empty,
    input  logic [CNT_W-1:0] in_median_pos,
    output logic             in_median_pos_rd,
    input  logic             in_median_pos_empty,
    input  logic [PX_W-1:0]  in_second_median_value,
    output logic             in_second_median_value_rd,
    input  logic             in_second_median_value_empty,
    output logic [PX_W-1:0]  out_px,
    output logic             out_px_wr,
    input  logic             out_px_full,
    output logic [PX_W-1:0]  out_pivot,
    output logic             out_pivot_wr,
    input  logic             out_pivot_full,
    output logic [CNT_W-1:0] out_buff_size,
    output logic             out_buff_size_wr,
    input  logic             out_buff_size_full,
    output logic [CNT_W-1:0] out_median_pos,
    output logic             out_median_pos_wr,
    input  logic             out_median_pos_full,
    output logic [PX_W-1:0]  out_second_median_value,
    output logic             out_second_median_value_wr,
    input  logic             out_second_median_value_full,
    output logic [PX_W-1:0]  out_median,
    output logic             out_median_wr,
    input  logic             out_median_full,
    output logic             err_oversize
);

    localparam int unsigned AW = $clog2(BUFF_DEPTH);
    localparam int unsigned SW = PX_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUFF_DEPTH);

    state_t state, state_nx;

    logic             run;
    logic [PX_W-1:0]  pivot, second;
    logic [CNT_W-1:0] size, pos, px_cnt, cnt_lo, cnt_eq, cnt_hi, rem;
    logic [PX_W-1:0]  lo_min, lo_max, hi_min, hi_max;
    logic             sel_hi;
    logic [AW-1:0]    rd_addr;
    logic             v_pivot, v_size, v_pos, v_second, v_median, v_px;

    logic             hdr_ready, hdr_take, px_take, px_lo, px_hi, rd_issue, hdr_left;
    logic             t_pivot, t_size, t_pos, t_second, t_median, t_px;
    logic [CNT_W-1:0] hdr_size_raw, lo_eq;
    logic             go_lo, go_found;
    logic [SW-1:0]    sum_lo, sum_hi;

    // Header acceptance and pixel intake
    assign hdr_ready = (FIRST_STAGE != 0) ||
                       (!in_pivot_empty && !in_buff_size_empty &&
                        !in_median_pos_empty && !in_second_median_value_empty);
    assign hdr_take  = run && (state == ST_HDR) && hdr_ready;
    assign in_pivot_rd               = hdr_take && (FIRST_STAGE == 0);
    assign in_buff_size_rd           = hdr_take && (FIRST_STAGE == 0);
    assign in_median_pos_rd          = hdr_take && (FIRST_STAGE == 0);
    assign in_second_median_value_rd = hdr_take && (FIRST_STAGE == 0);
    assign hdr_size_raw = (FIRST_STAGE != 0) ? DEPTH_C : in_buff_size;

    assign px_take  = (state == ST_FILL) && !in_px_empty;
    assign in_px_rd = px_take;
    assign px_lo    = in_px < pivot;
    assign px_hi    = in_px > pivot;

    // Output handshakes
    assign t_pivot  = v_pivot  && !out_pivot_full;
    assign t_size   = v_size   && !out_buff_size_full;
    assign t_pos    = v_pos    && !out_median_pos_full;
    assign t_second = v_second && !out_second_median_value_full;
    assign t_median = v_median && !out_median_full;
    assign t_px     = v_px     && !out_px_full;
    assign out_pivot_wr               = t_pivot;
    assign out_buff_size_wr           = t_size;
    assign out_median_pos_wr          = t_pos;
    assign out_second_median_value_wr = t_second;
    assign out_median_wr              = t_median;
    assign out_px_wr                  = t_px;
    assign hdr_left = (v_pivot && !t_pivot) || (v_size && !t_size) ||
                      (v_pos && !t_pos) || (v_second && !t_second);

    assign rd_issue = (state == ST_EMIT_PX) && (rem != '0) && (!v_px || t_px);

    // Median location relative to the partitions
    assign lo_eq    = cnt_lo + cnt_eq;
    assign go_lo    = pos < cnt_lo;
    assign go_found = !go_lo && (pos < lo_eq);
    assign sum_lo   = SW'(lo_min) + SW'(lo_max) + SW'(1);
    assign sum_hi   = SW'(hi_min) + SW'(hi_max) + SW'(1);

    median_buffer_ram #(.PX_W(PX_W), .DEPTH(BUFF_DEPTH)) u_ram (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (px_take && (px_lo || px_hi)),
        .wr_addr (px_lo ? AW'(cnt_lo) : (AW'(BUFF_DEPTH - 1) - AW'(cnt_hi))),
        .wr_data (in_px),
        .rd_en   (rd_issue),
        .rd_addr (rd_addr),
        .rd_data (out_px)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_HDR;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_HDR:      if (hdr_take && (hdr_size_raw != '0)) state_nx = ST_FILL;
            ST_FILL:     if (px_take && ((px_cnt + CNT_W'(1)) == size)) state_nx = ST_DECIDE;
            ST_DECIDE:   state_nx = go_found ? ST_FOUND : ST_EMIT_HDR;
            ST_EMIT_HDR: if (!hdr_left) state_nx = ST_EMIT_PX;
            ST_EMIT_PX:  if ((rem == '0) && (!v_px || t_px)) state_nx = ST_HDR;
            ST_FOUND:    if (t_median) state_nx = ST_HDR;
            default:     state_nx = ST_HDR;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            run <= 1'b0;
            pivot <= '0; second <= '0; size <= '0; pos <= '0;
            px_cnt <= '0; cnt_lo <= '0; cnt_eq <= '0; cnt_hi <= '0; rem <= '0;
            lo_min <= '0; lo_max <= '0; hi_min <= '0; hi_max <= '0;
            sel_hi <= 1'b0; rd_addr <= '0;
            v_pivot <= 1'b0; v_size <= 1'b0; v_pos <= 1'b0; v_second <= 1'b0;
            v_median <= 1'b0; v_px <= 1'b0;
            out_pivot <= '0; out_buff_size <= '0; out_median_pos <= '0;
            out_second_median_value <= '0; out_median <= '0;
            err_oversize <= 1'b0;
        end else begin
            run <= 1'b1;
            if (t_pivot)  v_pivot  <= 1'b0;
            if (t_size)   v_size   <= 1'b0;
            if (t_pos)    v_pos    <= 1'b0;
            if (t_second) v_second <= 1'b0;
            if (t_median) v_median <= 1'b0;

            if (hdr_take) begin
                pivot  <= (FIRST_STAGE != 0) ? PX_W'(DEF_PIVOT) : in_pivot;
                pos    <= (FIRST_STAGE != 0) ? CNT_W'(MEDIAN_POS) : in_median_pos;
                second <= (FIRST_STAGE != 0) ? '0 : in_second_median_value;
                size   <= (hdr_size_raw > DEPTH_C) ? DEPTH_C : hdr_size_raw;
                if (hdr_size_raw > DEPTH_C) err_oversize <= 1'b1;
                px_cnt <= '0; cnt_lo <= '0; cnt_eq <= '0; cnt_hi <= '0;
                lo_min <= '1; lo_max <= '0; hi_min <= '1; hi_max <= '0;
            end

            if (px_take) begin
                px_cnt <= px_cnt + CNT_W'(1);
                if (px_lo) begin
                    cnt_lo <= cnt_lo + CNT_W'(1);
                    if (in_px < lo_min) lo_min <= in_px;
                    if (in_px > lo_max) lo_max <= in_px;
                end else if (px_hi) begin
                    cnt_hi <= cnt_hi + CNT_W'(1);
                    if (in_px < hi_min) hi_min <= in_px;
                    if (in_px > hi_max) hi_max <= in_px;
                end else begin
                    cnt_eq <= cnt_eq + CNT_W'(1);
                end
            end

            if (state == ST_DECIDE) begin
                if (go_found) begin
                    out_median <= pivot;
                    v_median   <= 1'b1;
                end else begin
                    sel_hi         <= !go_lo;
                    rem            <= go_lo ? cnt_lo : cnt_hi;
                    rd_addr        <= go_lo ? '0 : AW'(BUFF_DEPTH - 1);
                    out_buff_size  <= go_lo ? cnt_lo : cnt_hi;
                    out_median_pos <= go_lo ? pos : (pos - lo_eq);
                    out_pivot      <= go_lo ? sum_lo[SW-1:1] : sum_hi[SW-1:1];
                    out_second_median_value <= second;
                    v_pivot <= 1'b1; v_size <= 1'b1; v_pos <= 1'b1; v_second <= 1'b1;
                end
            end

            // LO partition reads upward, HI downward; both reproduce arrival order
            if (rd_issue) begin
                rem     <= rem - CNT_W'(1);
                rd_addr <= sel_hi ? (rd_addr - AW'(1)) : (rd_addr + AW'(1));
                v_px    <= 1'b1;
            end else if (t_px) begin
                v_px <= 1'b0;
            end
        end
    end

endmodule
